// File: rtl/ram_block_mover_if.sv
// ============================================================================
//  Module   : ram_block_mover_if
//  Brief    : Control handshake and single-port RAM bus for the block mover.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ram_block_mover_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
);
    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic             mode;
    logic [AW-1:0]    src_addr;
    logic [AW-1:0]    dst_addr;
    logic [AW:0]      length;
    logic [WIDTH-1:0] fill_value;
    logic             busy;
    logic             done;
    logic [AW-1:0]    ram_addr;
    logic             ram_wren;
    logic [WIDTH-1:0] ram_data_in;
    logic [WIDTH-1:0] ram_data_out;

    // Controller side: issues requests, owns the RAM read data path.
    modport master (
        output start, mode, src_addr, dst_addr, length, fill_value, ram_data_out,
        input  busy, done, ram_addr, ram_wren, ram_data_in
    );

    // Mover side.
    modport slave (
        input  start, mode, src_addr, dst_addr, length, fill_value, ram_data_out,
        output busy, done, ram_addr, ram_wren, ram_data_in
    );
endinterface

`default_nettype wire

// File: rtl/ram_block_mover.sv
// ============================================================================
//  Module   : ram_block_mover
//  Brief    : Block COPY / FILL engine driving a single-port RAM directly.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ram_block_mover #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  wire logic         CLOCK,
    input  wire logic         RESET_N,
    ram_block_mover_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_mode;
    logic [AW-1:0]    r_src;
    logic [AW-1:0]    r_dst;
    logic [AW:0]      r_len;
    logic [AW:0]      r_idx;
    logic [WIDTH-1:0] r_fill;

    logic [AW:0]      w_len;
    logic [AW:0]      w_idx_next;
    logic             w_last;

    assign w_len      = (bus.length > c_DEPTH) ? c_DEPTH : bus.length;
    assign w_idx_next = r_idx + 1'b1;
    assign w_last     = (w_idx_next == r_len);

    // RAM bus outputs are loaded on the edge that enters each state, so the
    // values seen during RD/WR are already stable registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state         <= S_IDLE;
            r_mode          <= 1'b0;
            r_src           <= '0;
            r_dst           <= '0;
            r_len           <= '0;
            r_idx           <= '0;
            r_fill          <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_wren    <= 1'b0;
            bus.ram_data_in <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_src  <= bus.src_addr;
                        r_dst  <= bus.dst_addr;
                        r_len  <= w_len;
                        r_fill <= bus.fill_value;
                        r_idx  <= '0;
                        if (w_len == '0) begin
                            r_state  <= S_DONE;
                            bus.done <= 1'b1;
                        end else if (bus.mode) begin
                            r_state         <= S_WR;
                            bus.busy        <= 1'b1;
                            bus.ram_addr    <= bus.dst_addr;
                            bus.ram_wren    <= 1'b1;
                            bus.ram_data_in <= bus.fill_value;
                        end else begin
                            r_state      <= S_RD;
                            bus.busy     <= 1'b1;
                            bus.ram_addr <= bus.src_addr;
                        end
                    end
                end
                S_RD: begin
                    r_state         <= S_WR;
                    bus.ram_addr    <= r_dst + r_idx[AW-1:0];
                    bus.ram_wren    <= 1'b1;
                    bus.ram_data_in <= bus.ram_data_out;
                end
                S_WR: begin
                    r_idx <= w_idx_next;
                    if (w_last) begin
                        r_state      <= S_DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.ram_wren <= 1'b0;
                    end else if (r_mode) begin
                        bus.ram_addr    <= r_dst + w_idx_next[AW-1:0];
                        bus.ram_data_in <= r_fill;
                    end else begin
                        r_state      <= S_RD;
                        bus.ram_addr <= r_src + w_idx_next[AW-1:0];
                        bus.ram_wren <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b0;
                    bus.ram_wren <= 1'b0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ram_block_mover.sv
// ============================================================================
//  Module   : tb_ram_block_mover
//  Brief    : Directed vector bench for ram_block_mover with a behavioural RAM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_block_mover;
    logic CLOCK = 1'b0;
    logic RESET_N = 1'b0;
    logic mem_init = 1'b0;
    logic [31:0] mem [0:1023];
    int total = 0;
    int bad = 0;

    ram_block_mover_if #(.WIDTH(32), .DEPTH(1024)) bus ();

    ram_block_mover #(.WIDTH(32), .DEPTH(1024)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    // Behavioural RAM: async read, sync write, plus a one-cycle pattern preload.
    assign bus.ram_data_out = mem[bus.ram_addr];
    always @(posedge CLOCK) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h5000_0000 + i;
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_data_in;
        end
    end

    typedef struct {
        logic        mode;
        logic [9:0]  src;
        logic [9:0]  dst;
        logic [10:0] len;
        logic [31:0] fill;
        int          exp_cyc;
        int          exp_wr;
        int          exp_busy;
        logic [9:0]  a0, a1, a2;
        logic [31:0] v0, v1, v2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic init_mem();
        @(negedge CLOCK);
        mem_init = 1'b1;
        @(negedge CLOCK);
        mem_init = 1'b0;
    endtask

    task automatic drive_req(input logic m, input logic [9:0] s, input logic [9:0] d,
                             input logic [10:0] l, input logic [31:0] f);
        bus.mode       = m;
        bus.src_addr   = s;
        bus.dst_addr   = d;
        bus.length     = l;
        bus.fill_value = f;
        bus.start      = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc, nb, nw;
        init_mem();
        @(negedge CLOCK);
        drive_req(v.mode, v.src, v.dst, v.len, v.fill);
        @(negedge CLOCK);
        bus.start = 1'b0;
        cyc = 1; nb = 0; nw = 0;
        while (!bus.done && cyc < 3000) begin
            if (bus.busy) nb++;
            if (bus.ram_wren) nw++;
            @(negedge CLOCK);
            cyc++;
        end
        chk({tag, " done_latency"}, 64'(cyc), 64'(v.exp_cyc));
        chk({tag, " busy_cycles"}, 64'(nb), 64'(v.exp_busy));
        chk({tag, " write_count"}, 64'(nw), 64'(v.exp_wr));
        @(negedge CLOCK);
        chk({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
        chk({tag, " word_a0"}, 64'(mem[v.a0]), 64'(v.v0));
        chk({tag, " word_a1"}, 64'(mem[v.a1]), 64'(v.v1));
        chk({tag, " word_a2"}, 64'(mem[v.a2]), 64'(v.v2));
    endtask

    initial begin
        int k, nw, dcnt;

        //            mode  src      dst      len       fill          cyc   wr    busy  a0       a1       a2        v0            v1            v2
        vecs[0] = '{1'b1, 10'd0,    10'd10,  11'd4,    32'hDEADBEEF, 5,    4,    4,    10'd10,  10'd13,  10'd14,   32'hDEADBEEF, 32'hDEADBEEF, 32'h5000000E};
        vecs[1] = '{1'b0, 10'd0,    10'd100, 11'd3,    32'h0,        7,    3,    6,    10'd100, 10'd102, 10'd103,  32'h50000000, 32'h50000002, 32'h50000067};
        vecs[2] = '{1'b1, 10'd0,    10'd1022,11'd4,    32'h7,        5,    4,    4,    10'd1023,10'd1,   10'd2,    32'h7,        32'h7,        32'h50000002};
        vecs[3] = '{1'b1, 10'd0,    10'd5,   11'd0,    32'h9,        1,    0,    0,    10'd5,   10'd4,   10'd6,    32'h50000005, 32'h50000004, 32'h50000006};
        vecs[4] = '{1'b0, 10'd0,    10'd1,   11'd3,    32'h0,        7,    3,    6,    10'd1,   10'd2,   10'd3,    32'h50000000, 32'h50000000, 32'h50000000};
        vecs[5] = '{1'b0, 10'd1020, 10'd2,   11'd6,    32'h0,        13,   6,    12,   10'd2,   10'd6,   10'd7,    32'h500003FC, 32'h50000000, 32'h50000001};
        vecs[6] = '{1'b1, 10'd0,    10'd0,   11'd2000, 32'h12345678, 1025, 1024, 1024, 10'd0,   10'd512, 10'd1023, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[7] = '{1'b0, 10'd50,   10'd60,  11'd1,    32'h0,        3,    1,    2,    10'd60,  10'd61,  10'd59,   32'h50000032, 32'h5000003D, 32'h5000003B};

        bus.start = 1'b0;
        drive_req(1'b0, '0, '0, '0, '0);
        bus.start = 1'b0;

        repeat (3) @(negedge CLOCK);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset wren", 64'(bus.ram_wren), 64'd0);
        chk("reset addr", 64'(bus.ram_addr), 64'd0);
        chk("reset data_in", 64'(bus.ram_data_in), 64'd0);
        RESET_N = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while the fourth word of an 8-word copy is being written.
        init_mem();
        @(negedge CLOCK);
        drive_req(1'b0, 10'd0, 10'd100, 11'd8, 32'h0);
        @(negedge CLOCK);
        bus.start = 1'b0;
        nw = 0; k = 0;
        while (nw < 3 && k < 100) begin
            if (bus.ram_wren) nw++;
            @(negedge CLOCK);
            k++;
        end
        while (!bus.ram_wren && k < 100) begin
            @(negedge CLOCK);
            k++;
        end
        chk("midreset in_write", 64'(bus.ram_wren), 64'd1);
        RESET_N = 1'b0;
        #1;
        chk("midreset wren", 64'(bus.ram_wren), 64'd0);
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset addr", 64'(bus.ram_addr), 64'd0);
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("midreset word2", 64'(mem[102]), 64'h50000002);
        chk("midreset word3", 64'(mem[103]), 64'h50000067);
        chk("midreset word7", 64'(mem[107]), 64'h5000006B);
        chk("midreset idle", 64'(bus.busy), 64'd0);
        run_vec(vecs[0], "after_reset");

        // Start pulses while busy and while done is high must be dropped.
        init_mem();
        @(negedge CLOCK);
        drive_req(1'b1, 10'd0, 10'd200, 11'd3, 32'hAA);
        @(negedge CLOCK);
        dcnt = 0;
        for (int c = 1; c <= 30; c++) begin
            bus.start = 1'b0;
            if (bus.done) dcnt++;
            if (c == 2 || bus.done) drive_req(1'b1, 10'd0, 10'd300, 11'd2, 32'hBB);
            @(negedge CLOCK);
        end
        bus.start = 1'b0;
        chk("ignore done_count", 64'(dcnt), 64'd1);
        chk("ignore busy_end", 64'(bus.busy), 64'd0);
        chk("ignore first", 64'(mem[200]), 64'hAA);
        chk("ignore last", 64'(mem[202]), 64'hAA);
        chk("ignore past_end", 64'(mem[203]), 64'h500000CB);
        chk("ignore other_dst", 64'(mem[300]), 64'h5000012C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
